// File: rtl/l2_req_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// l2_req_rr_scheduler_if
//   Bundles the L1 FIFO-head side and the L2 request side of the round-robin
//   L2 request scheduler.
//
//   L1 side : enable, req_valid, req_rw, req_addr, req_data, req_id (to the
//             scheduler) and req_pop (from the scheduler, one-hot per FIFO).
//   L2 side : valid/rw/addr/data/id_L2_out and which_L1_out (registered
//             request from the scheduler), accept_L2 and rd_done_L2 (from
//             the L2), outstanding and credit_err (read-credit status).
//
//   master : the scheduler's view.
//   slave  : the environment's view (FIFOs + L2), i.e. the opposite directions.
// ---------------------------------------------------------------------------
interface l2_req_rr_scheduler_if #(
  parameter int NUM_L1S      = 2,
  parameter int NUM_L1S_LOG  = 1,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 256,
  parameter int CPU_ID_WIDTH = 2,
  parameter int OUTST_WIDTH  = 3
) ();

  // L1 FIFO-head side
  logic                            enable;
  logic [NUM_L1S-1:0]              req_valid;
  logic [NUM_L1S-1:0]              req_rw;
  logic [NUM_L1S*ADDR_WIDTH-1:0]   req_addr;
  logic [NUM_L1S*DATA_WIDTH-1:0]   req_data;
  logic [NUM_L1S*CPU_ID_WIDTH-1:0] req_id;
  logic [NUM_L1S-1:0]              req_pop;

  // L2 request side
  logic                            valid_L2_out;
  logic                            rw_L2_out;
  logic [ADDR_WIDTH-1:0]           addr_L2_out;
  logic [DATA_WIDTH-1:0]           data_L2_out;
  logic [CPU_ID_WIDTH-1:0]         id_L2_out;
  logic [NUM_L1S_LOG-1:0]          which_L1_out;
  logic                            accept_L2;
  logic                            rd_done_L2;

  // Read-credit status
  logic [OUTST_WIDTH-1:0]          outstanding;
  logic                            credit_err;

  modport master (
    input  enable, req_valid, req_rw, req_addr, req_data, req_id,
    input  accept_L2, rd_done_L2,
    output req_pop,
    output valid_L2_out, rw_L2_out, addr_L2_out, data_L2_out, id_L2_out, which_L1_out,
    output outstanding, credit_err
  );

  modport slave (
    output enable, req_valid, req_rw, req_addr, req_data, req_id,
    output accept_L2, rd_done_L2,
    input  req_pop,
    input  valid_L2_out, rw_L2_out, addr_L2_out, data_L2_out, id_L2_out, which_L1_out,
    input  outstanding, credit_err
  );

endinterface

// File: rtl/l2_req_rr_scheduler.sv
// ---------------------------------------------------------------------------
// l2_req_rr_scheduler
//   Round-robin scheduler that shares the single L2 request port between
//   NUM_L1S L1->L2 request FIFOs. It pops the granted FIFO head, registers the
//   packet and presents it to the L2 until the L2 accepts it. Reads accepted
//   by the L2 but not yet completed are capped at MAX_OUTSTANDING by a credit
//   counter; writes are never throttled by credits.
//
// Ports
//   clk    : single clock, all state on the rising edge
//   reset  : asynchronous, active-low reset
//   bus    : l2_req_rr_scheduler_if.master
//            - enable / req_* in, req_pop out (one-hot, combinational)
//            - *_L2_out and which_L1_out out (all registered)
//            - accept_L2 / rd_done_L2 in
//            - outstanding / credit_err out (registered)
// ---------------------------------------------------------------------------
module l2_req_rr_scheduler #(
  parameter int NUM_L1S         = 2,
  parameter int NUM_L1S_LOG     = 1,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 256,
  parameter int CPU_ID_WIDTH    = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int OUTST_WIDTH     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  l2_req_rr_scheduler_if.master bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // One extra bit so outstanding + pend_rd never wraps before the compare.
  localparam logic [OUTST_WIDTH:0]   MAX_EXT   = (OUTST_WIDTH+1)'(MAX_OUTSTANDING);
  localparam logic [NUM_L1S_LOG-1:0] PTR_RESET = NUM_L1S_LOG'(NUM_L1S-1);

  // Registered state
  logic [0:0]              state_q, state_d;
  logic [NUM_L1S_LOG-1:0]  rr_ptr_q, rr_ptr_d;
  logic                    rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CPU_ID_WIDTH-1:0] id_q, id_d;
  logic [NUM_L1S_LOG-1:0]  which_q, which_d;
  logic [OUTST_WIDTH-1:0]  outst_q, outst_d;
  logic                    cerr_q, cerr_d;

  // Combinational signals
  logic                    hold_s;
  logic                    pend_rd_s;
  logic                    room_s;
  logic [NUM_L1S-1:0]      elig_s;
  logic                    found_hi_s;
  logic                    found_lo_s;
  logic                    found_s;
  logic [NUM_L1S_LOG-1:0]  win_hi_s;
  logic [NUM_L1S_LOG-1:0]  win_lo_s;
  logic [NUM_L1S_LOG-1:0]  win_s;
  logic                    win_rw_s;
  logic [ADDR_WIDTH-1:0]   win_addr_s;
  logic [DATA_WIDTH-1:0]   win_data_s;
  logic [CPU_ID_WIDTH-1:0] win_id_s;
  logic                    slot_free_s;
  logic                    grant_s;
  logic [NUM_L1S-1:0]      req_pop_s;
  logic                    inc_s;
  logic                    dec_s;

  // Eligibility: a read needs a free credit, counting a read still sitting
  // on the L2 port (it will consume a credit when accepted).
  always_comb begin
    hold_s    = (state_q == ST_HOLD);
    pend_rd_s = hold_s & ~rw_q;
    room_s    = (({1'b0, outst_q} + {{OUTST_WIDTH{1'b0}}, pend_rd_s}) < MAX_EXT);
    elig_s    = bus.req_valid & (bus.req_rw | {NUM_L1S{room_s}});
  end

  // Round-robin winner: lowest eligible index above rr_ptr, else lowest
  // eligible index overall (wrap-around). Descending loops so the lowest
  // matching index is the last one written.
  always_comb begin
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    win_hi_s   = {NUM_L1S_LOG{1'b0}};
    win_lo_s   = {NUM_L1S_LOG{1'b0}};
    for (int i = NUM_L1S - 1; i >= 0; i--) begin
      found_hi_s = (elig_s[i] && (i > int'(rr_ptr_q))) ? 1'b1 : found_hi_s;
      win_hi_s   = (elig_s[i] && (i > int'(rr_ptr_q))) ? NUM_L1S_LOG'(i) : win_hi_s;
      found_lo_s = elig_s[i] ? 1'b1 : found_lo_s;
      win_lo_s   = elig_s[i] ? NUM_L1S_LOG'(i) : win_lo_s;
    end
    found_s = found_hi_s | found_lo_s;
    win_s   = found_hi_s ? win_hi_s : win_lo_s;
  end

  // Select the winning FIFO head's payload.
  always_comb begin
    win_rw_s   = 1'b0;
    win_addr_s = {ADDR_WIDTH{1'b0}};
    win_data_s = {DATA_WIDTH{1'b0}};
    win_id_s   = {CPU_ID_WIDTH{1'b0}};
    for (int i = 0; i < NUM_L1S; i++) begin
      win_rw_s   = (NUM_L1S_LOG'(i) == win_s) ? bus.req_rw[i] : win_rw_s;
      win_addr_s = (NUM_L1S_LOG'(i) == win_s) ? bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : win_addr_s;
      win_data_s = (NUM_L1S_LOG'(i) == win_s) ? bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] : win_data_s;
      win_id_s   = (NUM_L1S_LOG'(i) == win_s) ? bus.req_id[i*CPU_ID_WIDTH +: CPU_ID_WIDTH] : win_id_s;
    end
  end

  // Grant and one-hot pop. Gated by reset so req_pop is 0 while in reset
  // regardless of the FIFO heads.
  always_comb begin
    slot_free_s = (state_q == ST_IDLE) | (hold_s & bus.accept_L2);
    grant_s     = reset & bus.enable & slot_free_s & found_s;
    req_pop_s   = {NUM_L1S{1'b0}};
    for (int i = 0; i < NUM_L1S; i++) begin
      req_pop_s[i] = grant_s & (NUM_L1S_LOG'(i) == win_s);
    end
  end

  // Next-state logic for the L2 slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (bus.accept_L2) begin
          state_d = grant_s ? ST_HOLD : ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Packet capture: only on a grant, so a presented packet is stable until
  // accepted and the last packet simply lingers (valid low) after it.
  always_comb begin
    if (grant_s) begin
      rw_d     = win_rw_s;
      addr_d   = win_addr_s;
      data_d   = win_data_s;
      id_d     = win_id_s;
      which_d  = win_s;
      rr_ptr_d = win_s;
    end else begin
      rw_d     = rw_q;
      addr_d   = addr_q;
      data_d   = data_q;
      id_d     = id_q;
      which_d  = which_q;
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Read-credit counter; a completion at zero is flagged, not counted.
  always_comb begin
    inc_s  = bus.accept_L2 & hold_s & ~rw_q;
    dec_s  = bus.rd_done_L2 & (outst_q != {OUTST_WIDTH{1'b0}});
    cerr_d = cerr_q | (bus.rd_done_L2 & (outst_q == {OUTST_WIDTH{1'b0}}));
    case ({inc_s, dec_s})
      2'b10:   outst_d = outst_q + {{(OUTST_WIDTH-1){1'b0}}, 1'b1};
      2'b01:   outst_d = outst_q - {{(OUTST_WIDTH-1){1'b0}}, 1'b1};
      default: outst_d = outst_q;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= PTR_RESET;
      rw_q     <= 1'b0;
      addr_q   <= {ADDR_WIDTH{1'b0}};
      data_q   <= {DATA_WIDTH{1'b0}};
      id_q     <= {CPU_ID_WIDTH{1'b0}};
      which_q  <= {NUM_L1S_LOG{1'b0}};
      outst_q  <= {OUTST_WIDTH{1'b0}};
      cerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      id_q     <= id_d;
      which_q  <= which_d;
      outst_q  <= outst_d;
      cerr_q   <= cerr_d;
    end
  end

  assign bus.req_pop      = req_pop_s;
  assign bus.valid_L2_out = (state_q == ST_HOLD);
  assign bus.rw_L2_out    = rw_q;
  assign bus.addr_L2_out  = addr_q;
  assign bus.data_L2_out  = data_q;
  assign bus.id_L2_out    = id_q;
  assign bus.which_L1_out = which_q;
  assign bus.outstanding  = outst_q;
  assign bus.credit_err   = cerr_q;

endmodule

// File: tb/tb_l2_req_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_l2_req_rr_scheduler
//   Directed scenarios (reset, fairness, stall, credits, boundaries, enable
//   and async reset) followed by a randomized phase, all compared each cycle
//   against a transaction-level reference model of the scheduler.
// ---------------------------------------------------------------------------
module tb_l2_req_rr_scheduler;

  localparam int N    = 2;
  localparam int NL   = 1;
  localparam int AW   = 32;
  localparam int DW   = 256;
  localparam int IW   = 2;
  localparam int MAXO = 4;
  localparam int OW   = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  l2_req_rr_scheduler_if #(
    .NUM_L1S(N), .NUM_L1S_LOG(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .CPU_ID_WIDTH(IW), .OUTST_WIDTH(OW)
  ) bus ();

  l2_req_rr_scheduler #(
    .NUM_L1S(N), .NUM_L1S_LOG(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .CPU_ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO), .OUTST_WIDTH(OW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the presented packet, who had the last grant, and the
  // number of reads the L2 still owes.
  bit              m_valid;
  bit              m_rw;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  logic [IW-1:0]   m_id;
  int              m_which;
  int              m_last;
  int              m_out;
  bit              m_cerr;
  bit              exp_grant;
  int              exp_w;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_rw = 1'b0; m_addr = '0; m_data = '0; m_id = '0;
    m_which = 0; m_last = N - 1; m_out = 0; m_cerr = 1'b0;
    exp_grant = 1'b0; exp_w = 0;
  endtask

  // Who gets the port this cycle, from the current FIFO heads.
  task automatic model_eval();
    int  pend;
    bit  room;
    int  j;
    pend = (m_valid && !m_rw) ? 1 : 0;
    room = (m_out + pend) < MAXO;
    exp_grant = 1'b0;
    exp_w = 0;
    if (bus.enable === 1'b1 && (!m_valid || bus.accept_L2 === 1'b1)) begin
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!exp_grant && bus.req_valid[j] && (bus.req_rw[j] || room)) begin
          exp_grant = 1'b1;
          exp_w = j;
        end
      end
    end
  endtask

  task automatic model_step();
    int inc, dec;
    inc = (bus.accept_L2 && m_valid && !m_rw) ? 1 : 0;
    dec = (bus.rd_done_L2 && m_out > 0) ? 1 : 0;
    if (bus.rd_done_L2 && m_out == 0) m_cerr = 1'b1;
    m_out = m_out + inc - dec;
    if (exp_grant) begin
      m_valid = 1'b1;
      m_rw    = bus.req_rw[exp_w];
      m_addr  = bus.req_addr[exp_w*AW +: AW];
      m_data  = bus.req_data[exp_w*DW +: DW];
      m_id    = bus.req_id[exp_w*IW +: IW];
      m_which = exp_w;
      m_last  = exp_w;
    end else if (bus.accept_L2) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] ep;
    ep = '0;
    if (exp_grant) ep[exp_w] = 1'b1;
    check({tag, ":req_pop"},    bus.req_pop, ep);
    check({tag, ":valid"},      bus.valid_L2_out, m_valid);
    check({tag, ":rw"},         bus.rw_L2_out, m_rw);
    check({tag, ":addr"},       bus.addr_L2_out, m_addr);
    check({tag, ":data"},       bus.data_L2_out, m_data);
    check({tag, ":id"},         bus.id_L2_out, m_id);
    check({tag, ":which"},      bus.which_L1_out, m_which);
    check({tag, ":outstanding"}, bus.outstanding, m_out);
    check({tag, ":credit_err"}, bus.credit_err, m_cerr);
  endtask

  task automatic drive(input bit en, input logic [N-1:0] v, input logic [N-1:0] rw,
                       input bit acc, input bit done);
    bus.enable     = en;
    bus.req_valid  = v;
    bus.req_rw     = rw;
    bus.accept_L2  = acc;
    bus.rd_done_L2 = done;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW] = $urandom;
      for (int w = 0; w < DW / 32; w++) bus.req_data[i*DW + w*32 +: 32] = $urandom;
      bus.req_id[i*IW +: IW] = IW'($urandom_range(0, (1 << IW) - 1));
    end
  endtask

  // One clock: compare at the falling edge, advance the model, return 1 after the rising edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    model_eval();
    check_outputs(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // T1: reset with random inputs -> all outputs 0
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1'($urandom_range(0, 1)), N'($urandom), N'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      @(negedge clk);
      check_outputs("t1_in_reset");
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    drive(1'b1, 2'b01, 2'b11, 1'b0, 1'b0);
    cycle("t1_first");
    check("t1_valid_next", bus.valid_L2_out, 1'b1);
    check("t1_which_next", bus.which_L1_out, 1'b0);

    // T2: fairness, both writing, L2 always accepting
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 2'b11, 2'b11, 1'b1, 1'b0);
      cycle("t2_fair");
      check("t2_which_alt", bus.which_L1_out, k % 2);
      check("t2_no_bubble", bus.valid_L2_out, 1'b1);
    end

    // T3: stall with 0x1000 presented
    do_reset();
    drive(1'b1, 2'b01, 2'b11, 1'b0, 1'b0);
    bus.req_addr[0 +: AW] = 32'h0000_1000;
    cycle("t3_grant");
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
      cycle("t3_stall");
      check("t3_addr_stable", bus.addr_L2_out, 32'h0000_1000);
    end
    drive(1'b1, 2'b11, 2'b11, 1'b1, 1'b0);
    cycle("t3_accept");
    check("t3_next_which", bus.which_L1_out, 1'b1);

    // T4: credits, reads from L1 1 only
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 2'b10, 2'b00, 1'b1, 1'b0);
      cycle("t4_reads");
    end
    check("t4_outst_cap", bus.outstanding, 3'd4);
    check("t4_no_pop", bus.req_pop, 2'b00);
    drive(1'b1, 2'b10, 2'b00, 1'b1, 1'b1);
    cycle("t4_done");
    drive(1'b1, 2'b10, 2'b00, 1'b1, 1'b0);
    #1;
    check("t4_regrant_pop", bus.req_pop, 2'b10);
    cycle("t4_regrant");

    // T5: simultaneous inc/dec at 2, then completion at zero
    do_reset();
    drive(1'b1, 2'b10, 2'b00, 1'b0, 1'b0);
    cycle("t5_a");
    drive(1'b1, 2'b10, 2'b00, 1'b1, 1'b0);
    cycle("t5_b");
    drive(1'b1, 2'b10, 2'b00, 1'b1, 1'b0);
    cycle("t5_c");
    check("t5_outst_2", bus.outstanding, 3'd2);
    drive(1'b1, 2'b00, 2'b00, 1'b1, 1'b1);
    cycle("t5_incdec");
    check("t5_outst_still_2", bus.outstanding, 3'd2);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b1);
      cycle("t5_drain");
    end
    check("t5_cerr_clear", bus.credit_err, 1'b0);
    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b1);
    cycle("t5_underflow");
    check("t5_cerr_set", bus.credit_err, 1'b1);
    check("t5_outst_0", bus.outstanding, 3'd0);

    // T6: enable low in HOLD, then async reset in HOLD
    do_reset();
    drive(1'b1, 2'b01, 2'b11, 1'b0, 1'b0);
    cycle("t6_grant");
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 2'b11, 2'b11, 1'b0, 1'b0);
      cycle("t6_held");
    end
    drive(1'b0, 2'b11, 2'b11, 1'b1, 1'b0);
    cycle("t6_accept");
    drive(1'b0, 2'b11, 2'b11, 1'b0, 1'b0);
    cycle("t6_blocked");
    check("t6_idle", bus.valid_L2_out, 1'b0);
    drive(1'b1, 2'b01, 2'b11, 1'b0, 1'b0);
    cycle("t6_regrant");
    check("t6_hold", bus.valid_L2_out, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_valid", bus.valid_L2_out, 1'b0);
    check("t6_async_pop", bus.req_pop, 2'b00);
    check("t6_async_outst", bus.outstanding, 3'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Randomized phase
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 7) != 0), N'($urandom), N'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
